// File: rtl/core_link_pkg.sv
// Shared types and default constants for the host-to-core frame driver.
package core_link_pkg;

  localparam int DATA_W_DEF        = 16;
  localparam int FFT_IN_WORDS_DEF  = 64;
  localparam int FFT_OUT_WORDS_DEF = 128;
  localparam int FIR_IN_WORDS_DEF  = 16;
  localparam int FIR_OUT_WORDS_DEF = 16;
  localparam int WAIT_MAX_DEF      = 4096;

  typedef enum logic [1:0] {
    MODE_FFT = 2'b00,
    MODE_FIR = 2'b01
  } mode_e;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_HDR          = 4'd1,
    ST_HDR_GAP      = 4'd2,
    ST_SEND         = 4'd3,
    ST_SEND_GAP     = 4'd4,
    ST_WAIT_BUSY_HI = 4'd5,
    ST_WAIT_BUSY_LO = 4'd6,
    ST_RX_REQ       = 4'd7,
    ST_RX_WAIT      = 4'd8,
    ST_RX_OUT       = 4'd9,
    ST_RX_GAP       = 4'd10
  } drv_state_e;

  // Only the two low codes carry a job; the upper half of the mode space is reserved.
  function automatic logic mode_legal(input logic [1:0] mode);
    return (mode[1] == 1'b0);
  endfunction

endpackage

// File: rtl/core_frame_driver_if.sv
// Bundle of the host request/sample/result streams and the core word interface.
interface core_frame_driver_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_mode;
  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              smp_ready;
  logic [DATA_W-1:0] core_data_in;
  logic              core_data_in_valid;
  logic              core_tx_done;
  logic [DATA_W-1:0] core_data_out;
  logic              core_data_out_valid;
  logic              core_busy;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic              res_last;
  logic              drv_busy;
  logic [1:0]        err_flag;

  // Driver side.
  modport master (
    input  req_valid, req_mode, smp_data, smp_valid,
           core_data_out, core_data_out_valid, core_busy, res_ready,
    output req_ready, smp_ready, core_data_in, core_data_in_valid,
           core_tx_done, res_data, res_valid, res_last, drv_busy, err_flag
  );

  // Host and core side.
  modport slave (
    output req_valid, req_mode, smp_data, smp_valid,
           core_data_out, core_data_out_valid, core_busy, res_ready,
    input  req_ready, smp_ready, core_data_in, core_data_in_valid,
           core_tx_done, res_data, res_valid, res_last, drv_busy, err_flag
  );
endinterface

// File: rtl/link_timeout_ctr.sv
// Wait-cycle counter shared by the busy and result waits; expire flags the last allowed cycle.
module link_timeout_ctr #(
  parameter int WAIT_MAX = 4096
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] cnt_r;

  assign expire = (cnt_r == LAST);

  // Count cycles spent in a wait; saturate at the limit so expire stays asserted.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && !expire) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/core_frame_driver.sv
// Serialises a job (header + input frame) to the core, waits out its compute
// phase and streams the result frame back to the host one word at a time.
module core_frame_driver
  import core_link_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int FFT_IN_WORDS  = FFT_IN_WORDS_DEF,
  parameter int FFT_OUT_WORDS = FFT_OUT_WORDS_DEF,
  parameter int FIR_IN_WORDS  = FIR_IN_WORDS_DEF,
  parameter int FIR_OUT_WORDS = FIR_OUT_WORDS_DEF,
  parameter int WAIT_MAX      = WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rstb,
  core_frame_driver_if.master bus
);
  localparam logic [7:0] FFT_IN_LAST  = 8'(FFT_IN_WORDS - 1);
  localparam logic [7:0] FFT_OUT_LAST = 8'(FFT_OUT_WORDS - 1);
  localparam logic [7:0] FIR_IN_LAST  = 8'(FIR_IN_WORDS - 1);
  localparam logic [7:0] FIR_OUT_LAST = 8'(FIR_OUT_WORDS - 1);

  drv_state_e        state_r;
  logic [7:0]        in_cnt_r;
  logic [7:0]        out_cnt_r;
  logic [7:0]        in_last_r;
  logic [7:0]        out_last_r;
  logic              req_ready_r;
  logic              smp_ready_r;
  logic [DATA_W-1:0] core_data_in_r;
  logic              core_data_in_valid_r;
  logic              core_tx_done_r;
  logic [DATA_W-1:0] res_data_r;
  logic              res_valid_r;
  logic              res_last_r;
  logic              drv_busy_r;
  logic [1:0]        err_flag_r;

  logic              tmo_en_s;
  logic              tmo_clr_s;
  logic              tmo_expire_s;

  // Timer runs only in the three core waits and restarts whenever a wait is satisfied.
  always_comb begin
    tmo_en_s  = 1'b0;
    tmo_clr_s = 1'b1;
    case (state_r)
      ST_WAIT_BUSY_HI: begin
        tmo_en_s  = 1'b1;
        tmo_clr_s = bus.core_busy;
      end
      ST_WAIT_BUSY_LO: begin
        tmo_en_s  = 1'b1;
        tmo_clr_s = !bus.core_busy;
      end
      ST_RX_WAIT: begin
        tmo_en_s  = 1'b1;
        tmo_clr_s = bus.core_data_out_valid;
      end
      default: begin
        tmo_en_s  = 1'b0;
        tmo_clr_s = 1'b1;
      end
    endcase
  end

  link_timeout_ctr #(.WAIT_MAX(WAIT_MAX)) u_tmo (
    .clk    (clk),
    .rstb   (rstb),
    .clr    (tmo_clr_s),
    .en     (tmo_en_s),
    .expire (tmo_expire_s)
  );

  // Job sequencer; every output is set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r              <= ST_IDLE;
      in_cnt_r             <= 8'd0;
      out_cnt_r            <= 8'd0;
      in_last_r            <= 8'd0;
      out_last_r           <= 8'd0;
      req_ready_r          <= 1'b1;
      smp_ready_r          <= 1'b0;
      core_data_in_r       <= {DATA_W{1'b0}};
      core_data_in_valid_r <= 1'b0;
      core_tx_done_r       <= 1'b0;
      res_data_r           <= {DATA_W{1'b0}};
      res_valid_r          <= 1'b0;
      res_last_r           <= 1'b0;
      drv_busy_r           <= 1'b0;
      err_flag_r           <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (mode_legal(bus.req_mode)) begin
              in_last_r            <= (bus.req_mode == MODE_FIR) ? FIR_IN_LAST : FFT_IN_LAST;
              out_last_r           <= (bus.req_mode == MODE_FIR) ? FIR_OUT_LAST : FFT_OUT_LAST;
              in_cnt_r             <= 8'd0;
              out_cnt_r            <= 8'd0;
              err_flag_r           <= 2'b00;
              core_data_in_r       <= {{(DATA_W-2){1'b0}}, bus.req_mode};
              core_data_in_valid_r <= 1'b1;
              req_ready_r          <= 1'b0;
              drv_busy_r           <= 1'b1;
              state_r              <= ST_HDR;
            end else begin
              // Illegal request is consumed; flag it and stay put.
              err_flag_r[1] <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HDR: begin
          core_data_in_valid_r <= 1'b0;
          state_r              <= ST_HDR_GAP;
        end
        ST_HDR_GAP: begin
          smp_ready_r <= 1'b1;
          state_r     <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.smp_valid) begin
            core_data_in_r       <= bus.smp_data;
            core_data_in_valid_r <= 1'b1;
            smp_ready_r          <= 1'b0;
            state_r              <= ST_SEND_GAP;
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_SEND_GAP: begin
          core_data_in_valid_r <= 1'b0;
          if (in_cnt_r == in_last_r) begin
            state_r <= ST_WAIT_BUSY_HI;
          end else begin
            in_cnt_r    <= in_cnt_r + 8'd1;
            smp_ready_r <= 1'b1;
            state_r     <= ST_SEND;
          end
        end
        ST_WAIT_BUSY_HI: begin
          if (bus.core_busy) begin
            state_r <= ST_WAIT_BUSY_LO;
          end else if (tmo_expire_s) begin
            err_flag_r[0] <= 1'b1;
            req_ready_r   <= 1'b1;
            drv_busy_r    <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_BUSY_HI;
          end
        end
        ST_WAIT_BUSY_LO: begin
          if (!bus.core_busy) begin
            core_tx_done_r <= 1'b1;
            state_r        <= ST_RX_REQ;
          end else if (tmo_expire_s) begin
            err_flag_r[0] <= 1'b1;
            req_ready_r   <= 1'b1;
            drv_busy_r    <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT_BUSY_LO;
          end
        end
        ST_RX_REQ: begin
          core_tx_done_r <= 1'b0;
          state_r        <= ST_RX_WAIT;
        end
        ST_RX_WAIT: begin
          if (bus.core_data_out_valid) begin
            res_data_r  <= bus.core_data_out;
            res_valid_r <= 1'b1;
            res_last_r  <= (out_cnt_r == out_last_r);
            state_r     <= ST_RX_OUT;
          end else if (tmo_expire_s) begin
            err_flag_r[0] <= 1'b1;
            req_ready_r   <= 1'b1;
            drv_busy_r    <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            state_r <= ST_RX_WAIT;
          end
        end
        ST_RX_OUT: begin
          // Downstream back-pressure may last forever; no timeout here.
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            res_last_r  <= 1'b0;
            if (out_cnt_r == out_last_r) begin
              req_ready_r <= 1'b1;
              drv_busy_r  <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              out_cnt_r <= out_cnt_r + 8'd1;
              state_r   <= ST_RX_GAP;
            end
          end else begin
            state_r <= ST_RX_OUT;
          end
        end
        ST_RX_GAP: begin
          core_tx_done_r <= 1'b1;
          state_r        <= ST_RX_REQ;
        end
        default: begin
          core_data_in_valid_r <= 1'b0;
          core_tx_done_r       <= 1'b0;
          smp_ready_r          <= 1'b0;
          res_valid_r          <= 1'b0;
          res_last_r           <= 1'b0;
          req_ready_r          <= 1'b1;
          drv_busy_r           <= 1'b0;
          state_r              <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready          = req_ready_r;
  assign bus.smp_ready          = smp_ready_r;
  assign bus.core_data_in       = core_data_in_r;
  assign bus.core_data_in_valid = core_data_in_valid_r;
  assign bus.core_tx_done       = core_tx_done_r;
  assign bus.res_data           = res_data_r;
  assign bus.res_valid          = res_valid_r;
  assign bus.res_last           = res_last_r;
  assign bus.drv_busy           = drv_busy_r;
  assign bus.err_flag           = err_flag_r;

endmodule

// File: doc/core_frame_driver.md
Name: core_frame_driver

Overview:
Host-side counterpart of the processing core's word interface. Accepts a job request (mode plus sample stream) and serialises it to the core as a header word followed by the input frame, each word marked by a data_in_valid pulse. It waits out the core's compute phase, then pulls the result frame by pulsing tx_done and forwards each returned word on a ready/valid result stream. Sits between the host bus adapter and the core; runs on posedge clk, while the core samples on negedge, so the half-cycle margin is inherent.

Parameters:
DATA_W, 16, word width on all data paths
FFT_IN_WORDS, 64, samples sent in FFT mode
FFT_OUT_WORDS, 128, words retrieved in FFT mode
FIR_IN_WORDS, 16, samples sent in FIR mode
FIR_OUT_WORDS, 16, words retrieved in FIR mode
WAIT_MAX, 4096, cycle limit for any single wait on the core (busy or data_out_valid)

Ports:
clk  in  1  system clock, posedge
rstb  in  1  reset, asynchronous, active-low
req_valid  in  1  job request strobe
req_ready  out  1  high only in IDLE
req_mode  in  2  00 = FFT, 01 = FIR, 1x = illegal
smp_data  in  DATA_W  upstream sample
smp_valid  in  1  sample valid
smp_ready  out  1  sample accepted this cycle
core_data_in  out  DATA_W  word to core
core_data_in_valid  out  1  per-word pulse to core
core_tx_done  out  1  result-request pulse to core
core_data_out  in  DATA_W  result word from core
core_data_out_valid  in  1  core result valid
core_busy  in  1  core computing
res_data  out  DATA_W  result word downstream
res_valid  out  1  result valid
res_ready  in  1  downstream ready
res_last  out  1  high with the final result word
drv_busy  out  1  state != IDLE
err_flag  out  2  sticky: bit0 = timeout, bit1 = illegal mode; cleared on next accepted request

Behaviour:
- Reset: all outputs 0 except req_ready = 1; state = IDLE; counters 0. Reset asserted mid-job aborts immediately. No partial frame is resumed.
- States: IDLE, HDR, HDR_GAP, SEND, SEND_GAP, WAIT_BUSY_HI, WAIT_BUSY_LO, RX_REQ, RX_WAIT, RX_OUT, RX_GAP.
- IDLE:
  - On req_valid with a legal mode: latch mode, set in_cnt/out_cnt limits from mode, clear err_flag, go to HDR.
  - On an illegal mode: set err_flag[1] and stay in IDLE (request is consumed).
- HDR: core_data_in = {14'b0, mode}, core_data_in_valid = 1 for exactly 1 cycle, then HDR_GAP.
- HDR_GAP: valid low for 1 cycle, then SEND. This guarantees the header is not counted by the core's rising-edge sample capture.
- SEND:
  - smp_ready = 1. On smp_valid, drive the word with valid high for 1 cycle, then go to SEND_GAP, where valid is low for 1 cycle.
  - Each word therefore occupies at least 2 cycles.
  - After the in_cnt-th word, go to WAIT_BUSY_HI.
  - smp_ready is 0 in every other state; samples offered outside SEND are not consumed.
- WAIT_BUSY_HI: wait for core_busy = 1, then WAIT_BUSY_LO. WAIT_BUSY_LO: wait for core_busy = 0, then RX_REQ. If either wait exceeds WAIT_MAX cycles: set err_flag[0] and go to IDLE.
- RX_REQ: core_tx_done = 1 for 1 cycle (rising edge), then RX_WAIT.
- RX_WAIT:
  - Capture core_data_out on the first cycle core_data_out_valid = 1, then go to RX_OUT.
  - If WAIT_MAX expires: set err_flag[0] and go to IDLE.
- RX_OUT:
  - Hold res_valid = 1 and res_data stable until res_ready. res_ready low stalls indefinitely with no timeout.
  - res_last = 1 when out_cnt reaches its limit.
  - After the handshake: last word goes to IDLE, otherwise RX_GAP.
- RX_GAP: core_tx_done low for 1 cycle, then RX_REQ.
- Counters are 8 bits, count from 0, with no wrap. FFT_OUT_WORDS - 1 = 127 fits.
- core_data_in holds its last value between pulses; only valid is meaningful.
- A req_valid that arrives while not in IDLE is ignored, because req_ready = 0.

Decomposition:
- Package core_link_pkg holds:
  - mode enum: MODE_FFT = 2'b00, MODE_FIR = 2'b01
  - default word-count constants
  - driver state enum
- Sub-module link_timeout_ctr is natural: load/clear plus an expire output at WAIT_MAX. It is shared by the busy and result waits.

Test Plan:
- FFT job, samples 0..63, core model returns i*2 for 128 words -> header word 0x0000, then 64 valid pulses each followed by a low cycle; 128 tx_done pulses; res_data 0,2,…,254 with res_last on word 127 only.
- FIR job, 16 samples 0xA000+i -> header 0x0001; res_last on word 15; drv_busy returns to 0 and req_ready to 1 the cycle after the last handshake.
- req_mode = 2'b10 -> no core_data_in_valid pulse, err_flag = 2'b10, state remains IDLE.
- Core never raises core_busy -> err_flag[0] set after exactly WAIT_MAX cycles in WAIT_BUSY_HI; next legal request clears it.
- res_ready held low for 20 cycles on result word 5 -> res_data stable, no further tx_done pulse until the handshake, no timeout.
- rstb asserted during SEND at word 30 -> all outputs reset in the same cycle; a new FFT job afterwards completes normally from the header.
